gb_timer: RTL



---
 rtl/gb_timer_pkg.sv | 36 +++
 rtl/gb_timer_edge.sv | 32 +++
 rtl/gb_timer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gb_timer_pkg.sv
// Shared definitions for the DMG DIV/TIMA/TMA/TAC timer: register addresses,
// TAC clock-select and overflow-FSM encodings, and the select-to-counter-bit map.
package gb_timer_pkg;

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    typedef enum logic [1:0] {
        TAC_SEL_B9 = 2'b00,
        TAC_SEL_B3 = 2'b01,
        TAC_SEL_B5 = 2'b10,
        TAC_SEL_B7 = 2'b11
    } tac_sel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OVF_WAIT = 2'd1,
        RELOAD   = 2'd2
    } ovf_state_t;

    function automatic logic [3:0] sel_bit(input tac_sel_t sel);
        logic [3:0] idx;
        idx = 4'd9;
        case (sel)
            TAC_SEL_B9: idx = 4'd9;
            TAC_SEL_B3: idx = 4'd3;
            TAC_SEL_B5: idx = 4'd5;
            TAC_SEL_B7: idx = 4'd7;
            default:    idx = 4'd9;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gb_timer_edge.sv
// Tick source: selected system-counter bit gated by the TAC enable, falling-edge detected.
// Latency: tick is combinational in the cycle the gated signal is seen low after being high; no backpressure.
// Backpressure: none, tick is a free-running single-cycle pulse.
module gb_timer_edge
    import gb_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sys_cnt,
    input  logic        tac_en,
    input  tac_sel_t    tac_sel,
    output logic        tick
);

    logic sig;
    logic sig_q;

    // Gating with the enable before edge detection is what makes disabling the
    // timer while the selected bit is high produce a spurious tick.
    assign sig = tac_en & sys_cnt[sel_bit(tac_sel)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign tick = sig_q & ~sig;

endmodule

// File: rtl/gb_timer.sv
// DMG-compatible timer at FF04-FF07 with delayed TMA reload and one-cycle IRQ; optional STOP hold via GB_TIMER_STOP_EN.
// Latency: rdata registered one cycle after a read strobe; reload/IRQ OVF_DELAY cycles after TIMA overflow.
// Backpressure: none, every access completes in the cycle it is strobed.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter int          OVF_DELAY = 4,
    parameter logic [15:0] DIV_RESET = 16'h0000
)
(
    input  logic       clk,
    input  logic       rst_n,
`ifdef GB_TIMER_STOP_EN
    input  logic       stop,
`endif
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq_timer
);

    localparam logic [1:0] WAIT_LAST = 2'(OVF_DELAY - 2);

    logic [15:0] sys_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    ovf_state_t  state;
    logic [1:0]  wait_cnt;
    logic        tick;
    logic        cnt_hold;

    logic wr_div, wr_tima, wr_tma, wr_tac, rd_en;

    assign wr_div  = cs & we & (addr == ADDR_DIV);
    assign wr_tima = cs & we & (addr == ADDR_TIMA);
    assign wr_tma  = cs & we & (addr == ADDR_TMA);
    assign wr_tac  = cs & we & (addr == ADDR_TAC);
    assign rd_en   = cs & ~we;

`ifdef GB_TIMER_STOP_EN
    assign cnt_hold = stop;
`else
    assign cnt_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_cnt <= DIV_RESET;
        end else if (cnt_hold || wr_div) begin
            sys_cnt <= 16'h0000;
        end else begin
            sys_cnt <= sys_cnt + 16'd1;
        end
    end

    gb_timer_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sys_cnt (sys_cnt),
        .tac_en  (tac[2]),
        .tac_sel (tac_sel_t'(tac[1:0])),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            state     <= IDLE;
            wait_cnt  <= 2'd0;
            irq_timer <= 1'b0;
        end else begin
            irq_timer <= 1'b0;
            if (wr_tac) tac <= wdata[2:0];
            if (wr_tma) tma <= wdata;

            case (state)
                IDLE: begin
                    if (wr_tima) begin
                        tima <= wdata;
                    end else if (tick) begin
                        tima <= tima + 8'd1;
                        if (tima == 8'hFF) begin
                            state    <= OVF_WAIT;
                            wait_cnt <= 2'd0;
                        end
                    end
                end
                OVF_WAIT: begin
                    // A CPU write here cancels the pending reload entirely.
                    if (wr_tima) begin
                        tima  <= wdata;
                        state <= IDLE;
                    end else begin
                        if (tick) tima <= tima + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state <= RELOAD;
                        end else begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                    end
                end
                RELOAD: begin
                    tima      <= wr_tma ? wdata : tma;
                    irq_timer <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else if (rd_en) begin
            case (addr)
                ADDR_DIV:  rdata <= sys_cnt[15:8];
                ADDR_TIMA: rdata <= tima;
                ADDR_TMA:  rdata <= tma;
                default:   rdata <= {5'b11111, tac};
            endcase
        end
    end

endmodule
